// File: rtl/grid_port_arbiter.sv
// Round-robin arbiter sharing the single grid-memory port among N_REQ requesters, with burst lock.
// Optional grant timeout enabled by defining GRANT_TIMEOUT_EN.
module grid_port_arbiter #(
  parameter int unsigned N_REQ     = 3,
  parameter int unsigned ADDR_W    = 8,
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned MAX_BURST = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_REQ-1:0]          req,
  input  logic [N_REQ-1:0]          req_we,
  input  logic [N_REQ*ADDR_W-1:0]   req_addr,
  input  logic [N_REQ*DATA_W-1:0]   req_data,
  output logic [N_REQ-1:0]          gnt,
  output logic                      mem_en,
  output logic                      mem_we,
  output logic [ADDR_W-1:0]         mem_addr,
  output logic [DATA_W-1:0]         mem_wdata,
  input  logic [DATA_W-1:0]         mem_rdata,
  output logic [DATA_W-1:0]         rd_data,
  output logic [N_REQ-1:0]          rd_valid
);

  localparam int unsigned OWN_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_OWN  = 1'b1;

  logic [0:0]        state, state_d;
  logic [OWN_W-1:0]  owner, owner_d;
  logic [OWN_W-1:0]  rr_ptr, rr_ptr_d;
  logic [OWN_W-1:0]  rd_owner, rd_owner_d;
  logic [OWN_W-1:0]  pick_idx;
  logic              pick_found;
  logic [N_REQ-1:0]  gnt_d;
  logic              mem_en_d, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_d;
  logic [DATA_W-1:0] rd_data_d;
  logic [N_REQ-1:0]  rd_valid_d;
  logic              force_rel_c;

  function automatic logic [OWN_W-1:0] wrap_add(input logic [OWN_W-1:0] base, input int unsigned k);
    int unsigned s;
    s = 32'(base) + k;
    if (s >= N_REQ) s = s - N_REQ;
    return OWN_W'(s);
  endfunction

  function automatic logic [N_REQ-1:0] onehot(input logic [OWN_W-1:0] i);
    return N_REQ'(1) << i;
  endfunction

`ifdef GRANT_TIMEOUT_EN
  // Burst counter: cleared on grant, saturates at MAX_BURST; forces release only under contention.
  logic [7:0] burst_cnt, burst_cnt_d;
  assign force_rel_c = (burst_cnt == 8'(MAX_BURST)) && (|(req & ~onehot(owner)));
`else
  assign force_rel_c = 1'b0;
`endif

  // First requester at or after rr_ptr, wrapping.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = rr_ptr;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      if (!pick_found && req[wrap_add(rr_ptr, k)]) begin
        pick_found = 1'b1;
        pick_idx   = wrap_add(rr_ptr, k);
      end
    end
  end

  always_comb begin
    state_d     = state;
    owner_d     = owner;
    rr_ptr_d    = rr_ptr;
    rd_owner_d  = rd_owner;
    gnt_d       = gnt;
    mem_en_d    = 1'b0;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr;
    mem_wdata_d = mem_wdata;
`ifdef GRANT_TIMEOUT_EN
    burst_cnt_d = burst_cnt;
`endif
    // Read data returns to whoever issued the read, regardless of current grant.
    rd_valid_d  = (mem_en && !mem_we) ? onehot(rd_owner) : '0;
    rd_data_d   = (mem_en && !mem_we) ? mem_rdata : rd_data;

    case (state)
      S_IDLE: begin
        gnt_d = '0;
        if (pick_found) begin
          state_d = S_OWN;
          owner_d = pick_idx;
          gnt_d   = onehot(pick_idx);
`ifdef GRANT_TIMEOUT_EN
          burst_cnt_d = 8'd0;
`endif
        end
      end
      S_OWN: begin
        if (req[owner] && !force_rel_c) begin
          mem_en_d    = 1'b1;
          mem_we_d    = req_we[owner];
          mem_addr_d  = req_addr[32'(owner)*ADDR_W +: ADDR_W];
          mem_wdata_d = req_data[32'(owner)*DATA_W +: DATA_W];
          rd_owner_d  = owner;
`ifdef GRANT_TIMEOUT_EN
          burst_cnt_d = (burst_cnt < 8'(MAX_BURST)) ? burst_cnt + 8'd1 : burst_cnt;
`endif
        end else begin
          gnt_d    = '0;
          state_d  = S_IDLE;
          rr_ptr_d = wrap_add(owner, 1);
        end
      end
      default: begin
        state_d = S_IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      owner     <= '0;
      rr_ptr    <= '0;
      rd_owner  <= '0;
      gnt       <= '0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      rd_data   <= '0;
      rd_valid  <= '0;
`ifdef GRANT_TIMEOUT_EN
      burst_cnt <= 8'd0;
`endif
    end else begin
      state     <= state_d;
      owner     <= owner_d;
      rr_ptr    <= rr_ptr_d;
      rd_owner  <= rd_owner_d;
      gnt       <= gnt_d;
      mem_en    <= mem_en_d;
      mem_we    <= mem_we_d;
      mem_addr  <= mem_addr_d;
      mem_wdata <= mem_wdata_d;
      rd_data   <= rd_data_d;
      rd_valid  <= rd_valid_d;
`ifdef GRANT_TIMEOUT_EN
      burst_cnt <= burst_cnt_d;
`endif
    end
  end

endmodule
